// File: rtl/panel_emu_pkg.sv
// Shared types and constants for the panel response emulator: FSM state encoding,
// default luminance levels and the LFSR seed/tap mask used by the optional noise source.
package panel_emu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LAG  = 2'd1,
    RAMP = 2'd2
  } state_t;

  localparam logic [7:0] LVL_LO_DEF = 8'h10;
  localparam logic [7:0] LVL_HI_DEF = 8'hF0;

  // x^8+x^6+x^5+x^4+1 as a Fibonacci tap mask over state bits [7],[5],[4],[3]
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/panel_response_emulator_lfsr8.sv
// 8-bit Fibonacci LFSR (module lfsr8): advances once per enabled clock, reloads the
// package seed on synchronous reset. Used only by the PANEL_EMU_NOISE_EN build.
module lfsr8
  import panel_emu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [7:0] state
);

  logic feedback;

  assign feedback = ^(state & LFSR_TAPS);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LFSR_SEED;
    end else if (enable) begin
      state <= {state[6:0], feedback};
    end
  end

endmodule

// File: rtl/panel_response_emulator.sv
// Display + photodiode model: follows frame_index with a fixed input lag, then slews led
// toward the new level. Define PANEL_EMU_NOISE_EN to add +/-1 LSB LFSR dither on led.
module panel_response_emulator
  import panel_emu_pkg::*;
#(
  parameter int         LAG_CYCLES = 16,
  parameter int         RISE_DIV   = 1,
  parameter int         FALL_DIV   = 2,
  parameter int         STEP       = 1,
  parameter logic [7:0] LVL_LO     = LVL_LO_DEF,
  parameter logic [7:0] LVL_HI     = LVL_HI_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        loop_en,
  input  logic        frame_index,
  output logic [7:0]  led,
  output logic        settled,
  output logic [15:0] trans_cnt
);

  localparam int DIV_MAX = (RISE_DIV > FALL_DIV) ? RISE_DIV : FALL_DIV;
  localparam int DW      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int LW      = (LAG_CYCLES > 0) ? $clog2(LAG_CYCLES + 1) : 1;

  localparam logic [LW-1:0] LAG_LOAD = LW'(LAG_CYCLES);
  localparam logic [7:0]    STEP8    = 8'(STEP);

  state_t        state;
  logic [7:0]    led_lvl;
  logic          tgt_dark;
  logic          frame_q;
  logic [LW-1:0] lag_cnt;
  logic [DW-1:0] div_cnt;

  logic          edge_det;
  logic [7:0]    target_lvl;
  logic [7:0]    pend_lvl;
  logic [7:0]    lag_lvl;
  logic          ramping;
  logic          up;
  logic [7:0]    gap;
  logic [31:0]   div_lim;
  logic          div_tc;
  logic [7:0]    ramp_led;
  logic [DW-1:0] ramp_div;

  assign edge_det   = (frame_index != frame_q);
  assign target_lvl = tgt_dark    ? LVL_LO : LVL_HI;
  assign pend_lvl   = frame_index ? LVL_LO : LVL_HI;
  assign lag_lvl    = frame_q     ? LVL_LO : LVL_HI;

  // The slew engine runs whenever led is off target, including during LAG (old target).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ramping  = (led_lvl != target_lvl);
    up       = (target_lvl > led_lvl);
    gap      = up ? (target_lvl - led_lvl) : (led_lvl - target_lvl);
    div_lim  = up ? 32'(RISE_DIV) : 32'(FALL_DIV);
    div_tc   = ((32'(div_cnt) + 32'd1) >= div_lim);
    ramp_led = led_lvl;
    ramp_div = '0;
    if (ramping) begin
      if (div_tc) begin
        // Clamp the last step to the target: no overshoot and no 8-bit wrap.
        if (gap > STEP8) ramp_led = up ? (led_lvl + STEP8) : (led_lvl - STEP8);
        else             ramp_led = target_lvl;
      end else begin
        ramp_div = div_cnt + DW'(1);
      end
    end
  end

  // NOTE: all state below is sequential and uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_lvl   <= LVL_LO;
      tgt_dark  <= 1'b1;
      frame_q   <= 1'b1;
      state     <= IDLE;
      lag_cnt   <= '0;
      div_cnt   <= '0;
      settled   <= 1'b1;
      trans_cnt <= '0;
    end else if (loop_en) begin
      led_lvl <= ramp_led;
      div_cnt <= ramp_div;
      if (edge_det) begin
        frame_q <= frame_index;
        if (frame_index == tgt_dark) begin
          // Pending level returned to the current target: drop the lag.
          lag_cnt <= '0;
          state   <= (ramp_led == target_lvl) ? IDLE : RAMP;
          settled <= (ramp_led == target_lvl);
        end else if (LAG_CYCLES == 0) begin
          tgt_dark  <= frame_index;
          trans_cnt <= trans_cnt + 16'd1;
          led_lvl   <= led_lvl;
          div_cnt   <= '0;
          state     <= RAMP;
          settled   <= (led_lvl == pend_lvl);
        end else begin
          lag_cnt <= LAG_LOAD;
          state   <= LAG;
          settled <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            settled <= 1'b1;
          end
          LAG: begin
            if (lag_cnt <= LW'(1)) begin
              tgt_dark  <= frame_q;
              trans_cnt <= trans_cnt + 16'd1;
              led_lvl   <= led_lvl;
              div_cnt   <= '0;
              lag_cnt   <= '0;
              state     <= RAMP;
              settled   <= (led_lvl == lag_lvl);
            end else begin
              lag_cnt <= lag_cnt - LW'(1);
              settled <= 1'b0;
            end
          end
          RAMP: begin
            settled <= (ramp_led == target_lvl);
            if (ramp_led == target_lvl) state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef PANEL_EMU_NOISE_EN
  logic [7:0] lfsr_q;

  lfsr8 u_lfsr8 (
    .clk    (clk),
    .reset  (reset),
    .enable (loop_en),
    .state  (lfsr_q)
  );

  // Dither is applied only to the output; settled and the FSM see the clean level.
  always_comb begin
    led = led_lvl;
    case (lfsr_q[1:0])
      2'b00:   if (led_lvl != 8'h00) led = led_lvl - 8'd1;
      2'b11:   if (led_lvl != 8'hFF) led = led_lvl + 8'd1;
      default: led = led_lvl;
    endcase
  end
`else
  assign led = led_lvl;
`endif

endmodule
